// File: rtl/controlador_sequenciador.sv
// SAP-1 controller-sequencer: a one-hot T-state ring plus opcode decode into the control word.
// Optional macro SAP_EARLY_END_EN: short instructions return to T1 right after their last active state.
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       cls,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic       halted
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic advance;
    logic halt_now;
    logic last_state;
    logic active;

    assign advance  = run && !halted;
    assign halt_now = (tstate == T4) && (opcode == OP_HLT);
    assign active   = !cls && run && !halted;

    // Decide whether the current T-state is the final one of this instruction.
    always_comb begin
        last_state = 1'b0;
`ifdef SAP_EARLY_END_EN
        if (opcode == OP_LDA)
            last_state = (tstate == T5);
        else if (opcode == OP_OUT)
            last_state = (tstate == T4);
        else if ((opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_HLT))
            last_state = (tstate == T6);
        else
            last_state = (tstate == T3);
`else
        last_state = (tstate == T6);
`endif
    end

    always_ff @(posedge clk or posedge cls) begin
        if (cls) begin
            tstate <= T1;
            halted <= 1'b0;
        end else if (advance) begin
            if (halt_now)
                halted <= 1'b1;
            else if (last_state)
                tstate <= T1;
            else
                tstate <= {tstate[4:0], tstate[5]};
        end
    end

    // Control word is purely a decode of the held T-state and the IR opcode.
    always_comb begin
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_out  = 1'b0;
        out_load = 1'b0;
        if (active) begin
            case (tstate)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
